// File: rtl/target_tb_if.sv
// Target-side user port of the PCI core: address/data bus, BAR hit,
// command/byte enables, data-phase strobes and the target response signals.
interface target_tb_if;
    logic [31:0] adio_out;
    logic [31:0] adio_in;
    logic        addr_vld;
    logic [7:0]  base_hit;
    logic [3:0]  s_cbe;
    logic        s_wrdn;
    logic        s_data;
    logic        s_data_vld;
    logic        s_src_en;
    logic        s_ready;
    logic        s_term;
    logic        s_abort;

    modport master (
        output adio_out, addr_vld, base_hit, s_cbe, s_wrdn, s_data, s_data_vld, s_src_en,
        input  adio_in, s_ready, s_term, s_abort
    );

    modport slave (
        input  adio_out, addr_vld, base_hit, s_cbe, s_wrdn, s_data, s_data_vld, s_src_en,
        output adio_in, s_ready, s_term, s_abort
    );
endinterface

// File: rtl/target_tb.sv
// PCI target user application: burst word memory behind one BAR with byte-lane
// writes, prefetched reads, disconnect at top of memory and target abort.
// Optional retry injection on the first RETRY_CNT accesses: define TARGET_RETRY_EN.
module target_tb #(
    parameter int BAR       = 0,
    parameter int AW        = 4,
    parameter int RETRY_CNT = 1
) (
    input  logic        CLK,
    input  logic        reset_n,
    target_tb_if.slave  bus
);

    typedef enum logic [2:0] {
        T_IDLE,
        T_XFER,
        T_RTY,
        T_ABORT,
        T_WAIT
    } state_t;

    localparam int            DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] PTR_LAST = '1;

    state_t        state, state_nxt;
    logic [AW-1:0] ptr, ptr_nxt;
    logic [31:0]   rdata_q, rdata_nxt;
    logic          rd_last, rd_last_nxt;
    logic          ready_q, term_q, abort_q;
    logic          s_dataq;
    logic          s_data_fell;
    logic          claim;
    logic          cmd_ok;
    logic [AW-1:0] claim_ptr;
    logic          mem_we;
    logic          src_adv;
    logic          unused_sink;
    logic [31:0]   mem [DEPTH];

`ifdef TARGET_RETRY_EN
    logic [7:0]    retry_left, retry_nxt;
`endif

    assign claim       = bus.addr_vld & bus.base_hit[BAR];
    assign cmd_ok      = (bus.s_cbe == 4'b0110) | (bus.s_cbe == 4'b0111);
    assign claim_ptr   = bus.adio_out[AW+1:2];
    assign s_data_fell = s_dataq & ~bus.s_data;
    // A write in the final (falling) cycle still lands; a read advance there does not.
    assign mem_we      = (state == T_XFER) & bus.s_data_vld & bus.s_wrdn;
    assign src_adv     = (state == T_XFER) & bus.s_src_en & ~bus.s_wrdn & ~s_data_fell;

    assign unused_sink = ^{bus.base_hit, bus.adio_out, 8'(RETRY_CNT)};

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        rdata_nxt   = rdata_q;
        rd_last_nxt = rd_last;
`ifdef TARGET_RETRY_EN
        retry_nxt   = retry_left;
`endif
        case (state)
            T_IDLE: begin
                if (claim) begin
                    ptr_nxt = claim_ptr;
                    if (!cmd_ok) begin
                        state_nxt = T_ABORT;
                    end
`ifdef TARGET_RETRY_EN
                    else if (retry_left != 8'd0) begin
                        state_nxt = T_RTY;
                        retry_nxt = retry_left - 8'd1;
                    end
`endif
                    else begin
                        state_nxt = T_XFER;
                        // Prefetch so read data is valid in the first data cycle.
                        if (!bus.s_wrdn) begin
                            rdata_nxt   = mem[claim_ptr];
                            rd_last_nxt = (claim_ptr == PTR_LAST);
                            ptr_nxt     = claim_ptr + AW'(1);
                        end
                    end
                end
            end
            T_XFER: begin
                if (s_data_fell) begin
                    state_nxt = T_WAIT;
                end
                if (mem_we) begin
                    ptr_nxt = ptr + AW'(1);
                end else if (src_adv) begin
                    rdata_nxt   = mem[ptr];
                    rd_last_nxt = (ptr == PTR_LAST);
                    ptr_nxt     = ptr + AW'(1);
                end
            end
            T_RTY, T_ABORT: begin
                if (s_data_fell) begin
                    state_nxt = T_WAIT;
                end
            end
            T_WAIT: begin
                state_nxt = T_IDLE;
            end
            default: begin
                state_nxt = T_IDLE;
            end
        endcase
    end

    // Control and response registers; outputs follow the next state so they are valid
    // in the first cycle of that state.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state   <= T_IDLE;
            ptr     <= '0;
            rdata_q <= '0;
            rd_last <= 1'b0;
            s_dataq <= 1'b0;
            ready_q <= 1'b0;
            term_q  <= 1'b0;
            abort_q <= 1'b0;
`ifdef TARGET_RETRY_EN
            retry_left <= 8'(RETRY_CNT);
`endif
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            rdata_q <= rdata_nxt;
            rd_last <= rd_last_nxt;
            s_dataq <= bus.s_data;
            ready_q <= (state_nxt == T_XFER);
            abort_q <= (state_nxt == T_ABORT);
            // Disconnect when the word about to move is the top word, so a burst never wraps.
            term_q  <= (state_nxt == T_RTY) | (state_nxt == T_ABORT) |
                       ((state_nxt == T_XFER) &
                        (bus.s_wrdn ? (ptr_nxt == PTR_LAST) : rd_last_nxt));
`ifdef TARGET_RETRY_EN
            retry_left <= retry_nxt;
`endif
        end
    end

    // Word memory; deliberately not reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (!bus.s_cbe[i]) begin
                    mem[ptr][8*i +: 8] <= bus.adio_out[8*i +: 8];
                end
            end
        end
    end

    assign bus.adio_in = rdata_q;
    assign bus.s_ready = ready_q;
    assign bus.s_term  = term_q;
    assign bus.s_abort = abort_q;

endmodule

// File: tb/tb_target_tb.sv
// Bench for target_tb: directed vector table, randomized transactions against a
// word-array reference model, and a mid-burst asynchronous reset sequence.
module tb_target_tb;

    localparam int BAR       = 2;
    localparam int AW        = 4;
    localparam int RETRY_CNT = 1;
    localparam int DEPTH     = 2 ** AW;
    localparam int LAST      = DEPTH - 1;
    localparam logic [31:0] ADDR_MASK = 32'((DEPTH - 1) << 2);

    localparam int K_NONE  = 0;
    localparam int K_ABORT = 1;
    localparam int K_RTY   = 2;
    localparam int K_XFER  = 3;

    logic CLK;
    logic reset_n;

    target_tb_if tif();

    target_tb #(.BAR(BAR), .AW(AW), .RETRY_CNT(RETRY_CNT)) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (tif.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_m [DEPTH];
    bit          mvalid [DEPTH];
    int          retry_m;

    typedef struct {
        logic [3:0]  cmd;
        bit          hit;
        bit          wr;
        int          start;
        int          n;
        logic [3:0]  be;
        logic [31:0] d0;
        logic [31:0] dstep;
        int          exp_moved;
    } vec_t;

    vec_t tbl [16];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic idle_inputs();
        tif.addr_vld   = 1'b0;
        tif.base_hit   = 8'h00;
        tif.s_cbe      = 4'hF;
        tif.s_wrdn     = 1'b0;
        tif.s_data     = 1'b0;
        tif.s_data_vld = 1'b0;
        tif.s_src_en   = 1'b0;
        tif.adio_out   = 32'h0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, 32'(tif.s_ready), 32'd0);
        chk({tag, "_term"},  32'(tif.s_term),  32'd0);
        chk({tag, "_abort"}, 32'(tif.s_abort), 32'd0);
    endtask

    // One initiator transaction. For non-transfer outcomes n is the number of
    // data-window cycles held before s_data drops.
    task automatic xact(input logic [3:0] cmd, input bit hit, input bit wr, input int start,
                        input int n, input logic [3:0] be, input logic [31:0] d0,
                        input logic [31:0] dstep, input bit waits,
                        output int moved, output int kind);
        int          cur;
        bit          fin;
        logic [31:0] d;
        if (!hit)                                  kind = K_NONE;
        else if (cmd != 4'b0110 && cmd != 4'b0111) kind = K_ABORT;
        else if (retry_m > 0) begin
            kind = K_RTY;
            retry_m--;
        end else                                   kind = K_XFER;
        moved = 0;
        cur   = start;
        @(negedge CLK);
        tif.addr_vld = 1'b1;
        tif.base_hit = hit ? (8'($urandom) | (8'h1 << BAR)) : (8'($urandom) & ~(8'h1 << BAR));
        tif.s_cbe    = cmd;
        tif.s_wrdn   = wr;
        tif.adio_out = ($urandom & ~ADDR_MASK) | (32'(start) << 2);
        @(negedge CLK);
        tif.addr_vld = 1'b0;
        tif.base_hit = 8'h00;
        tif.s_data   = 1'b1;
        tif.s_cbe    = be;
        fin = 1'b0;
        for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
            tif.s_data_vld = 1'b0;
            tif.s_src_en   = 1'b0;
            if (kind == K_XFER) begin
                chk("xfer_ready", 32'(tif.s_ready), 32'd1);
                chk("xfer_term",  32'(tif.s_term),  32'(cur == LAST));
                chk("xfer_abort", 32'(tif.s_abort), 32'd0);
                if (!wr && mvalid[cur]) chk("rdata", tif.adio_in, mem_m[cur]);
                if (!(waits && $urandom_range(3) == 0)) begin
                    if (wr) begin
                        d = d0 + dstep * 32'(moved);
                        tif.adio_out   = d;
                        tif.s_data_vld = 1'b1;
                        for (int i = 0; i < 4; i++)
                            if (!be[i]) mem_m[cur][8*i +: 8] = d[8*i +: 8];
                        if (be == 4'h0) mvalid[cur] = 1'b1;
                    end else begin
                        tif.s_src_en = 1'b1;
                    end
                    moved++;
                    if (cur == LAST || moved == n) fin = 1'b1;
                    cur++;
                end
            end else begin
                chk("resp_ready", 32'(tif.s_ready), 32'd0);
                chk("resp_term",  32'(tif.s_term),  32'(kind != K_NONE));
                chk("resp_abort", 32'(tif.s_abort), 32'(kind == K_ABORT));
                tif.s_data_vld = 1'b1;
                tif.adio_out   = $urandom;
                if (cyc + 1 >= n) fin = 1'b1;
            end
            @(negedge CLK);
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL xact_timeout: got %0d words expected %0d", moved, n);
        end
        tif.s_data     = 1'b0;
        tif.s_data_vld = 1'b0;
        tif.s_src_en   = 1'b0;
        tif.adio_out   = $urandom;
        @(negedge CLK);
        chk_quiet("wait");
        @(negedge CLK);
        chk_quiet("idle");
        idle_inputs();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int moved, kind;
        logic [3:0] rcmd, rbe;
        bit rhit, rwr;
        int rsel;

        tbl[0]  = '{4'b0111, 1'b1, 1'b1,  0, 16, 4'h0, 32'h0100_0000, 32'h0101_0101, 16};
        tbl[1]  = '{4'b0111, 1'b1, 1'b1,  0, 16, 4'h0, 32'h0100_0000, 32'h0101_0101, 16};
        tbl[2]  = '{4'b0111, 1'b1, 1'b1,  2,  3, 4'h0, 32'h1111_1111, 32'h1111_1111,  3};
        tbl[3]  = '{4'b0110, 1'b1, 1'b0,  2,  3, 4'h0, 32'h0,         32'h0,          3};
        tbl[4]  = '{4'b0111, 1'b1, 1'b1,  5,  1, 4'h0, 32'h0000_0000, 32'h0,          1};
        tbl[5]  = '{4'b0111, 1'b1, 1'b1,  5,  1, 4'hA, 32'hAABB_CCDD, 32'h0,          1};
        tbl[6]  = '{4'b0110, 1'b1, 1'b0,  5,  1, 4'h0, 32'h0,         32'h0,          1};
        tbl[7]  = '{4'b0111, 1'b1, 1'b1, 14,  4, 4'h0, 32'hE0E0_E0E0, 32'h0000_0001,  2};
        tbl[8]  = '{4'b0110, 1'b1, 1'b0,  0,  1, 4'h0, 32'h0,         32'h0,          1};
        tbl[9]  = '{4'b0110, 1'b1, 1'b0, 13,  5, 4'h0, 32'h0,         32'h0,          3};
        tbl[10] = '{4'b0010, 1'b1, 1'b0,  3,  3, 4'h0, 32'h0,         32'h0,          0};
        tbl[11] = '{4'b0011, 1'b1, 1'b1,  3,  2, 4'h0, 32'h0,         32'h0,          0};
        tbl[12] = '{4'b0111, 1'b0, 1'b1,  3,  3, 4'h0, 32'h0,         32'h0,          0};
        tbl[13] = '{4'b0110, 1'b1, 1'b0,  3,  1, 4'h0, 32'h0,         32'h0,          1};
        tbl[14] = '{4'b1010, 1'b1, 1'b0,  0,  1, 4'h0, 32'h0,         32'h0,          0};
        tbl[15] = '{4'b0110, 1'b1, 1'b0,  0, 16, 4'h0, 32'h0,         32'h0,         16};

        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]  = 32'h0;
            mvalid[i] = 1'b0;
        end
`ifdef TARGET_RETRY_EN
        retry_m = RETRY_CNT;
`else
        retry_m = 0;
`endif

        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(negedge CLK);
        chk_quiet("reset");
        chk("reset_adio", tif.adio_in, 32'h0);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            xact(tbl[i].cmd, tbl[i].hit, tbl[i].wr, tbl[i].start, tbl[i].n, tbl[i].be,
                 tbl[i].d0, tbl[i].dstep, 1'b0, moved, kind);
            if (kind == K_XFER) chk($sformatf("vec%0d_moved", i), 32'(moved), 32'(tbl[i].exp_moved));
        end

        for (int t = 0; t < 40; t++) begin
            rsel = $urandom_range(9);
            rhit = 1'b1;
            rbe  = 4'h0;
            if (rsel <= 3) begin
                rcmd = 4'b0111;
                rwr  = 1'b1;
                rbe  = ($urandom_range(2) == 0) ? 4'($urandom) : 4'h0;
            end else if (rsel <= 7) begin
                rcmd = 4'b0110;
                rwr  = 1'b0;
            end else if (rsel == 8) begin
                rcmd = 4'($urandom_range(5)) & 4'b0011;
                rwr  = rcmd[0];
            end else begin
                rcmd = 4'b0111;
                rwr  = 1'b1;
                rhit = 1'b0;
            end
            xact(rcmd, rhit, rwr, $urandom_range(LAST), $urandom_range(6, 1), rbe,
                 $urandom, $urandom, 1'b1, moved, kind);
        end

        // Asynchronous reset in the middle of a write burst.
        @(negedge CLK);
        tif.addr_vld = 1'b1;
        tif.base_hit = 8'h1 << BAR;
        tif.s_cbe    = 4'b0111;
        tif.s_wrdn   = 1'b1;
        tif.adio_out = 32'd4 << 2;
        @(negedge CLK);
        chk("rst_seq_ready0", 32'(tif.s_ready), 32'd1);
        tif.addr_vld   = 1'b0;
        tif.base_hit   = 8'h00;
        tif.s_data     = 1'b1;
        tif.s_data_vld = 1'b1;
        tif.s_cbe      = 4'h0;
        tif.adio_out   = 32'h5A5A_A5A5;
        mem_m[4]       = 32'h5A5A_A5A5;
        mvalid[4]      = 1'b1;
        @(negedge CLK);
        chk("rst_seq_ready1", 32'(tif.s_ready), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk_quiet("async_rst");
        chk("async_rst_adio", tif.adio_in, 32'h0);
        idle_inputs();
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
`ifdef TARGET_RETRY_EN
        retry_m = RETRY_CNT;
`else
        retry_m = 0;
`endif
        xact(4'b0110, 1'b1, 1'b0, 4, 2, 4'h0, 32'h0, 32'h0, 1'b0, moved, kind);
        xact(4'b0110, 1'b1, 1'b0, 4, 2, 4'h0, 32'h0, 32'h0, 1'b0, moved, kind);
        if (kind == K_XFER) chk("post_rst_moved", 32'(moved), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
